uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver for the SOC's RXD pin; counterpart of the SOC UART transmitter driving TXD.
- Frame format is 8N1, LSB first. The line idles high.
- Synchronises RXD, detects the start bit and samples each bit at its centre.
- Delivers each byte over a valid/ready handshake, with one-byte holding, and flags framing and overrun errors.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency.
- BAUD_RATE, 115200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (104), clocks per bit period. Overridable directly; must be >= 4.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- RXD  input  1  serial line, asynchronous to CLK, idle high.
- rx_data  output  8  received byte, stable while rx_valid=1.
- rx_valid  output  1  byte available; held until consumed.
- rx_ready  input  1  consumer accepts; a transfer occurs on a cycle where rx_valid&&rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte completed while the previous byte was unconsumed.

Behaviour:
- Synchroniser: 2 flops on RXD, both reset to 1. The FSM uses only rxd_s (the 2nd flop). The pin-to-FSM delay of 2 cycles is part of all latencies below.
- Reset (RESET=0, async): state=IDLE, counters=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0. Reset mid-frame aborts the frame and no byte is delivered.
- Counter: clk_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
- IDLE: if rxd_s==0, go to START with clk_cnt=0.
- START: when clk_cnt==CLKS_PER_BIT/2-1 (integer division), sample rxd_s.
  - 0: go to DATA, clk_cnt=0, bit_idx=0.
  - 1: false start (glitch); go to IDLE with no outputs.
- DATA: when clk_cnt==CLKS_PER_BIT-1, sample rxd_s into shift register bit[bit_idx] (LSB first) and reset clk_cnt.
  - bit_idx==7: go to STOP.
  - otherwise: bit_idx+1.
- STOP: when clk_cnt==CLKS_PER_BIT-1, sample rxd_s.
  - 1: deliver the byte, go to IDLE.
  - 0: frame_err=1 for one cycle, discard the byte, go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. A held-low line therefore produces exactly one frame_err, not repeated frames.
- Delivery, evaluated in the cycle the stop bit is sampled high; updates take effect on the next edge:
  - rx_valid==0, or rx_valid&&rx_ready this cycle: rx_data<=shift register, rx_valid<=1. No overrun.
  - rx_valid==1 and rx_ready==0: rx_data and rx_valid unchanged, new byte dropped, overrun=1 for one cycle.
- Consume: rx_valid&&rx_ready with no simultaneous delivery gives rx_valid<=0 next cycle. rx_ready while rx_valid=0 has no effect.
- Timing:
  - Every sample point is CLKS_PER_BIT after the previous one.
  - The first data sample is at CLKS_PER_BIT/2 + CLKS_PER_BIT cycles after rxd_s falls.
  - rx_valid rises 1 cycle after the stop-bit sample.
  - Total latency from the RXD falling edge to rx_valid=1 = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
  - A back-to-back next start bit is accepted because STOP exits at mid stop bit.
- frame_err and overrun are registered and default to 0 on every cycle not listed above.
- No parity. Only 1 stop bit is checked; extra idle time is tolerated.

Test Plan (CLKS_PER_BIT=16 unless noted; the bench drives RXD 16 clocks per bit):
- Byte 0x55, rx_ready=1 → rx_valid pulses exactly 1 cycle with rx_data=0x55, 2+8+144+1=155 cycles after the RXD falling edge. frame_err=0, overrun=0.
- Bytes 0xA3 then 0x0F back-to-back (no idle gap), rx_ready=0 until the first is read → rx_data=0xA3 held stable. After one rx_ready cycle rx_valid=0. Then 0x0F is delivered if it completes after the read; the bench checks both orderings, and in the unread case overrun=1 and rx_data stays 0xA3.
- RXD low for 3 cycles then high → no rx_valid, no frame_err; FSM back in IDLE; a following 0x81 is received correctly.
- Frame 0xFF with stop bit driven 0, RXD then held low 40 cycles → exactly one frame_err pulse, rx_valid stays 0. After RXD returns high, 0x3C is received correctly.
- RESET=0 asserted during bit 4 of frame 0x96 → outputs zero immediately (async). After release, RXD is idle for 16 cycles, then 0x96 is sent → rx_data=0x96, no stale bits.
- CLKS_PER_BIT=5 (odd, START sample at clk_cnt==1), byte 0xC3 → rx_data=0xC3.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver for the RXD pin with mid-bit sampling,
// one-byte valid/ready holding and framing/overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic rxd_m, rxd_s;
  logic deliver, ferr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    deliver = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n      = '0;
          shift_n[idx] = rxd_s;
          if (idx == 3'd7) state_n = STOP;
          else idx_n = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          deliver = rxd_s;
          ferr    = !rxd_s;
          state_n = rxd_s ? IDLE : BRK;
        end
      end
      BRK: begin
        // a held-low line yields one error, then waits for idle
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
